bus_arbiter2: RTL and testbench

- Two-master arbiter that shares one FemtoRV-style memory bus slave (bram or a peripheral decode tree) between master 0 (CPU) and master 1 (auxiliary master: loader or DMA).
- Latches each master's one-cycle strobe and serialises the accesses with round-robin priority.
- Drives the masters' rbusy/wbusy stall inputs and returns registered read data to each master.

---
 rtl/bus_arb_pkg.sv | 31 +++
 rtl/arb_req_latch.sv | 76 +++++++
 rtl/bus_arbiter2.sv | 177 +++++++++++++++++
 tb/tb_bus_arbiter2.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb_pkg
// Description : Shared types and constants for the two-master bus arbiter.
//               The optional ARB_FIXED_PRIO_EN build macro is consumed by
//               bus_arbiter2 and does not change anything in this package.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

  // Arbiter FSM encoding
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } arb_state_t;

  // Operation held in a master's pending latch
  typedef enum logic [0:0] {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_t;

  // Master identifiers (also the value presented on grant)
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Width of the read-latency down-counter (RD_LAT up to 15)
  localparam int CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/arb_req_latch.sv
`default_nettype none
// ============================================================================
// Module      : arb_req_latch
// Description : Per-master pending request register. Captures a one-cycle
//               write (nonzero wmask) or read strobe, generates the
//               registered rbusy/wbusy stalls and holds the returned read
//               data until the next read of this master completes.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_req_latch
  import bus_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              reset,
  // master side
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     wdata,
  input  logic [DW/8-1:0]   wmask,
  input  logic              rstrb,
  output logic [DW-1:0]     rdata,
  output logic              rbusy,
  output logic              wbusy,
  // arbiter side
  input  logic              wr_done,
  input  logic              rd_done,
  input  logic [DW-1:0]     s_rdata,
  output logic              pending,
  output arb_op_t           op,
  output logic [AW-1:0]     lat_addr,
  output logic [DW-1:0]     lat_wdata,
  output logic [DW/8-1:0]   lat_wmask
);

  // Capture a new request when idle; release it when the arbiter completes it.
  // Strobes arriving while a request is held (including its completion cycle)
  // are dropped, and a write strobe masks a simultaneous read strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= 1'b0;
      op        <= OP_RD;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
      rdata     <= '0;
      rbusy     <= 1'b0;
      wbusy     <= 1'b0;
    end else if (wr_done) begin
      pending <= 1'b0;
      wbusy   <= 1'b0;
    end else if (rd_done) begin
      pending <= 1'b0;
      rbusy   <= 1'b0;
      rdata   <= s_rdata;
    end else if (!pending) begin
      if (|wmask) begin
        pending   <= 1'b1;
        op        <= OP_WR;
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_wmask <= wmask;
        wbusy     <= 1'b1;
      end else if (rstrb) begin
        pending   <= 1'b1;
        op        <= OP_RD;
        lat_addr  <= addr;
        lat_wmask <= '0;
        rbusy     <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter2
// Description : Two-master arbiter in front of one FemtoRV-style bus slave.
//               Latches each master's strobe, serialises accesses with
//               round-robin priority and returns registered read data.
//               Build macro ARB_FIXED_PRIO_EN: master 0 always wins contention
//               (last-grant still tracks grant but does not steer selection).
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter2
  import bus_arb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     m0_addr,
  input  logic [DW-1:0]     m0_wdata,
  input  logic [DW/8-1:0]   m0_wmask,
  input  logic              m0_rstrb,
  output logic [DW-1:0]     m0_rdata,
  output logic              m0_rbusy,
  output logic              m0_wbusy,
  input  logic [AW-1:0]     m1_addr,
  input  logic [DW-1:0]     m1_wdata,
  input  logic [DW/8-1:0]   m1_wmask,
  input  logic              m1_rstrb,
  output logic [DW-1:0]     m1_rdata,
  output logic              m1_rbusy,
  output logic              m1_wbusy,
  output logic [AW-1:0]     s_addr,
  output logic [DW-1:0]     s_wdata,
  output logic [DW/8-1:0]   s_wmask,
  output logic              s_rstrb,
  input  logic [DW-1:0]     s_rdata,
  output logic              grant
);

  localparam int               MW       = DW / 8;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              last_grant, last_grant_nxt;
  logic [1:0]        wr_done, rd_done;

  logic [1:0]        pend;
  arb_op_t           op0, op1;
  logic [AW-1:0]     addr0, addr1;
  logic [DW-1:0]     wdata0, wdata1;
  logic [MW-1:0]     wmask0, wmask1;

  logic              winner;
  arb_op_t           win_op;
  logic [AW-1:0]     win_addr;
  logic [DW-1:0]     win_wdata;
  logic [MW-1:0]     win_wmask;

  arb_req_latch #(.AW(AW), .DW(DW)) u_req0 (
    .clk       (clk),
    .reset     (reset),
    .addr      (m0_addr),
    .wdata     (m0_wdata),
    .wmask     (m0_wmask),
    .rstrb     (m0_rstrb),
    .rdata     (m0_rdata),
    .rbusy     (m0_rbusy),
    .wbusy     (m0_wbusy),
    .wr_done   (wr_done[0]),
    .rd_done   (rd_done[0]),
    .s_rdata   (s_rdata),
    .pending   (pend[0]),
    .op        (op0),
    .lat_addr  (addr0),
    .lat_wdata (wdata0),
    .lat_wmask (wmask0)
  );

  arb_req_latch #(.AW(AW), .DW(DW)) u_req1 (
    .clk       (clk),
    .reset     (reset),
    .addr      (m1_addr),
    .wdata     (m1_wdata),
    .wmask     (m1_wmask),
    .rstrb     (m1_rstrb),
    .rdata     (m1_rdata),
    .rbusy     (m1_rbusy),
    .wbusy     (m1_wbusy),
    .wr_done   (wr_done[1]),
    .rd_done   (rd_done[1]),
    .s_rdata   (s_rdata),
    .pending   (pend[1]),
    .op        (op1),
    .lat_addr  (addr1),
    .lat_wdata (wdata1),
    .lat_wmask (wmask1)
  );

  // Pick the winner among pending requests; only latched state is used.
  always_comb begin
    winner = M0;
    if (pend[0] && pend[1]) begin
`ifdef ARB_FIXED_PRIO_EN
      winner = M0;
`else
      winner = (last_grant == M0) ? M1 : M0;
`endif
    end else if (pend[1]) begin
      winner = M1;
    end
    win_op    = (winner == M1) ? op1    : op0;
    win_addr  = (winner == M1) ? addr1  : addr0;
    win_wdata = (winner == M1) ? wdata1 : wdata0;
    win_wmask = (winner == M1) ? wmask1 : wmask0;
  end

  // FSM state, latency counter and last-grant registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last_grant <= M1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Next-state logic and slave-side drive; writes issue back-to-back from
  // IDLE, reads park in RD_WAIT until the slave data is due.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    grant          = last_grant;
    s_addr         = '0;
    s_wdata        = '0;
    s_wmask        = '0;
    s_rstrb        = 1'b0;
    wr_done        = 2'b00;
    rd_done        = 2'b00;
    unique case (state)
      ST_IDLE: begin
        if (|pend) begin
          grant          = winner;
          last_grant_nxt = winner;
          s_addr         = win_addr;
          if (win_op == OP_WR) begin
            s_wdata         = win_wdata;
            s_wmask         = win_wmask;
            wr_done[winner] = 1'b1;
          end else begin
            s_rstrb   = 1'b1;
            cnt_nxt   = LAT_INIT;
            state_nxt = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        s_addr  = (last_grant == M1) ? addr1 : addr0;
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          rd_done[last_grant] = 1'b1;
          state_nxt           = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter2
// Description : Randomised scoreboard bench for bus_arbiter2. A transaction
//               model of the arbitration rules plus a small word memory acting
//               as the slave predicts every cycle's busy/grant/rdata/s_addr
//               and every slave access; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter2;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int MW     = DW / 8;
  localparam int RD_LAT = 3;
  localparam int N_CYC  = 3000;

  typedef struct {
    int            cyc;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic          gnt;
  } slv_ev_t;

  typedef struct {
    int            cyc;
    logic [3:0]    busy;   // {wbusy1, rbusy1, wbusy0, rbusy0}
    logic          gnt;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
    logic [AW-1:0] saddr;
  } cyc_exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addr_in  [2];
  logic [DW-1:0] wdata_in [2];
  logic [MW-1:0] wmask_in [2];
  logic          rstrb_in [2];
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [MW-1:0] s_wmask;
  logic          s_rstrb;
  logic [DW-1:0] s_rdata;
  logic          grant;

  bus_arbiter2 #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_addr  (addr_in[0]),
    .m0_wdata (wdata_in[0]),
    .m0_wmask (wmask_in[0]),
    .m0_rstrb (rstrb_in[0]),
    .m0_rdata (m0_rdata),
    .m0_rbusy (m0_rbusy),
    .m0_wbusy (m0_wbusy),
    .m1_addr  (addr_in[1]),
    .m1_wdata (wdata_in[1]),
    .m1_wmask (wmask_in[1]),
    .m1_rstrb (rstrb_in[1]),
    .m1_rdata (m1_rdata),
    .m1_rbusy (m1_rbusy),
    .m1_wbusy (m1_wbusy),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wmask  (s_wmask),
    .s_rstrb  (s_rstrb),
    .s_rdata  (s_rdata),
    .grant    (grant)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  slv_ev_t  slv_q [$];
  cyc_exp_t cyc_q [$];

  // ---------------- reference model state ----------------
  logic          p_v     [2];
  logic          p_wr    [2];
  logic [AW-1:0] p_addr  [2];
  logic [DW-1:0] p_wdata [2];
  logic [MW-1:0] p_wmask [2];
  logic          last;
  logic          rd_act;
  int            rd_m, rd_iss_cyc, rd_done_cyc;
  logic [DW-1:0] rd_val;
  logic [DW-1:0] rdata_exp [2];
  logic [DW-1:0] mem [8];
  int            nrst = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      p_v[i]       = 1'b0;
      p_wr[i]      = 1'b0;
      p_addr[i]    = '0;
      p_wdata[i]   = '0;
      p_wmask[i]   = '0;
      rdata_exp[i] = '0;
    end
    last   = 1'b1;
    rd_act = 1'b0;
    rd_m   = 0;
  endtask

  // One clock cycle: predict this cycle's outputs, drive the slave data and
  // new master strobes, then advance the model to the next cycle.
  task automatic step(input bit do_rst, input bit quiet);
    cyc_exp_t      ce;
    slv_ev_t       ev;
    logic          pv_start [2];
    logic          clr [2];
    logic [DW-1:0] srd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [MW-1:0] wm;
    logic          rs;
    int            w, r, idx;
    srd      = $urandom();
    pv_start = p_v;
    clr[0]   = 1'b0;
    clr[1]   = 1'b0;
    ce.cyc   = cyc;
    ce.busy  = {p_v[1] & p_wr[1], p_v[1] & ~p_wr[1], p_v[0] & p_wr[0], p_v[0] & ~p_wr[0]};
    ce.rd0   = rdata_exp[0];
    ce.rd1   = rdata_exp[1];
    ce.gnt   = last;
    ce.saddr = '0;
    if (rd_act) begin
      ce.saddr = p_addr[rd_m];
      if (cyc == rd_done_cyc) srd = rd_val;
    end else if (p_v[0] || p_v[1]) begin
      if (p_v[0] && p_v[1]) begin
`ifdef ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = last ? 0 : 1;
`endif
      end else begin
        w = p_v[0] ? 0 : 1;
      end
      last     = w[0];
      ce.gnt   = w[0];
      ce.saddr = p_addr[w];
      ev.cyc   = cyc;
      ev.rd    = !p_wr[w];
      ev.addr  = p_addr[w];
      ev.wdata = p_wr[w] ? p_wdata[w] : '0;
      ev.wmask = p_wr[w] ? p_wmask[w] : '0;
      ev.gnt   = w[0];
      slv_q.push_back(ev);
      idx = int'(p_addr[w][4:2]);
      if (p_wr[w]) begin
        for (int b = 0; b < MW; b++)
          if (p_wmask[w][b]) mem[idx][8*b +: 8] = p_wdata[w][8*b +: 8];
        clr[w] = 1'b1;
      end else begin
        rd_act      = 1'b1;
        rd_m        = w;
        rd_iss_cyc  = cyc;
        rd_done_cyc = cyc + RD_LAT;
        rd_val      = mem[idx];
      end
    end
    cyc_q.push_back(ce);
    s_rdata = srd;

    for (int i = 0; i < 2; i++) begin
      a = $urandom();
      a[1:0] = 2'b00;
      d  = $urandom();
      wm = '0;
      rs = 1'b0;
      if (!quiet && !do_rst) begin
        r = $urandom_range(0, 99);
        if (pv_start[i] ? (r < 5) : (r < 40)) begin
          case ($urandom_range(0, 2))
            0:       rs = 1'b1;
            1:       wm = MW'($urandom_range(1, 15));
            default: begin rs = 1'b1; wm = MW'($urandom_range(1, 15)); end
          endcase
        end
      end
      addr_in[i]  = a;
      wdata_in[i] = d;
      wmask_in[i] = wm;
      rstrb_in[i] = rs;
      if (!pv_start[i]) begin
        if (wm != '0) begin
          p_v[i] = 1'b1; p_wr[i] = 1'b1; p_addr[i] = a; p_wdata[i] = d; p_wmask[i] = wm;
        end else if (rs) begin
          p_v[i] = 1'b1; p_wr[i] = 1'b0; p_addr[i] = a; p_wmask[i] = '0;
        end
      end
    end

    if (rd_act && cyc == rd_done_cyc) begin
      p_v[rd_m]       = 1'b0;
      rdata_exp[rd_m] = rd_val;
      rd_act          = 1'b0;
    end
    for (int i = 0; i < 2; i++)
      if (clr[i]) p_v[i] = 1'b0;
    if (do_rst) model_reset();
  endtask

  // Monitor: compare the DUT against the expectations queued for this cycle.
  always @(negedge clk) begin
    cyc_exp_t ce;
    slv_ev_t  ev;
    if (cyc_q.size() > 0 && cyc_q[0].cyc == cyc) begin
      ce = cyc_q.pop_front();
      chk("busy", 64'({m1_wbusy, m1_rbusy, m0_wbusy, m0_rbusy}), 64'(ce.busy));
      chk("grant", 64'(grant), 64'(ce.gnt));
      chk("m0_rdata", 64'(m0_rdata), 64'(ce.rd0));
      chk("m1_rdata", 64'(m1_rdata), 64'(ce.rd1));
      chk("s_addr", 64'(s_addr), 64'(ce.saddr));
    end
    if (s_rstrb === 1'b1 || (s_wmask !== '0 && s_wmask !== 'x)) begin
      if (slv_q.size() == 0 || slv_q[0].cyc != cyc) begin
        chk("unexpected_access", 64'({s_rstrb, s_wmask}), 64'(0));
      end else begin
        ev = slv_q.pop_front();
        chk("acc_rstrb", 64'(s_rstrb), 64'(ev.rd));
        chk("acc_wmask", 64'(s_wmask), 64'(ev.wmask));
        chk("acc_wdata", 64'(s_wdata), 64'(ev.wdata));
        chk("acc_addr", 64'(s_addr), 64'(ev.addr));
      end
    end else if (slv_q.size() > 0 && slv_q[0].cyc <= cyc) begin
      ev = slv_q.pop_front();
      chk("missed_access", 64'({s_rstrb, s_wmask}), 64'({ev.rd, ev.wmask}));
    end
  end

  initial begin
    bit rst_now;
    reset = 1'b1;
    s_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      addr_in[i] = '0; wdata_in[i] = '0; wmask_in[i] = '0; rstrb_in[i] = 1'b0;
    end
    for (int k = 0; k < 8; k++) mem[k] = $urandom();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int n = 0; n < N_CYC + 12; n++) begin
      rst_now = (n < N_CYC) && rd_act && (cyc == rd_iss_cyc + 1) && (nrst < 4)
                && ($urandom_range(0, 2) == 0);
      if (rst_now) nrst++;
      reset = rst_now;
      step(rst_now, n >= N_CYC);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    chk("leftover_cycle_exp", 64'(cyc_q.size()), 64'(0));
    chk("leftover_slave_exp", 64'(slv_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
